// File: rtl/cnn_acc_pkg.sv
// -----------------------------------------------------------------------------
// cnn_acc_pkg
// Shared definitions for the CNN accelerator filter path:
//   - FILTER_WIDTH_DEF / FILTER_ROW_DEF : defaults shared with the filter
//     scratchpad (word width and depth in words)
//   - fsl_state_t                       : filter_spad_loader FSM encoding
//   - clog2()                           : elaboration-time ceil(log2(x))
// No ports.
// -----------------------------------------------------------------------------
package cnn_acc_pkg;

    localparam int FILTER_WIDTH_DEF = 16;
    localparam int FILTER_ROW_DEF   = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } fsl_state_t;

    // Number of address bits needed to index 'value' entries.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/filter_spad_loader_if.sv
// -----------------------------------------------------------------------------
// filter_spad_loader_if
// Filter word stream between the upstream source and filter_spad_loader.
//   in_data  : stream word (FILTER_WIDTH bits)
//   in_valid : source has a word on in_data
//   in_ready : loader takes the word this cycle
// Handshake: a word transfers on the rising edge where in_valid && in_ready.
// The source holds in_data stable while in_valid is high and not yet accepted;
// in_ready may depend on loader state only, never on in_valid.
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface filter_spad_loader_if
    import cnn_acc_pkg::*;
#(
    parameter int FILTER_WIDTH = FILTER_WIDTH_DEF
);
    logic [FILTER_WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/ring_ptr_add.sv
// -----------------------------------------------------------------------------
// ring_ptr_add
// Combinational modular pointer advance: o_sum = (i_ptr + i_inc) mod MOD.
// Valid for i_ptr < MOD and i_inc <= MOD, so one conditional subtract is
// enough. The sum is formed in AW+1 bits to hold the carry.
// Ports:
//   i_ptr [AW-1:0] : current pointer
//   i_inc [AW:0]   : increment, 0..MOD
//   o_sum [AW-1:0] : advanced pointer
// -----------------------------------------------------------------------------
module ring_ptr_add #(
    parameter int AW  = 4,
    parameter int MOD = 12
) (
    input  logic [AW-1:0] i_ptr,
    input  logic [AW:0]   i_inc,
    output logic [AW-1:0] o_sum
);

    logic [AW:0] w_sum;

    always_comb begin
        w_sum = {1'b0, i_ptr} + i_inc;
        if (w_sum >= (AW+1)'(MOD)) begin
            w_sum = w_sum - (AW+1)'(MOD);
        end
    end

    assign o_sum = w_sum[AW-1:0];

endmodule

// File: rtl/filter_spad_loader.sv
// -----------------------------------------------------------------------------
// filter_spad_loader
// Pulls filter words from a valid/ready stream and writes them into the filter
// scratchpad, which is used as a circular buffer of whole filters. Reports to
// the PE controller how many complete filters are resident (o_filters_avail)
// and the row where the oldest one starts (o_rd_base).
//
// Optional feature: define FSL_STALL_CNT_EN to add o_stall_cnt, a saturating
// count of LOAD cycles where the source is valid but the loader is full.
//
// Ports:
//   i_clk, i_rst        : clock (rising edge), asynchronous active-low reset
//   i_start             : 1-cycle pulse, latches i_filter_size / i_num_filters
//   i_filter_size       : words per filter, 1..FILTER_ROW
//   i_num_filters       : filters for this job; 0 is a no-op
//   s_in                : filter word stream (slave side)
//   i_filter_done       : consumer releases the oldest resident filter
//   o_spad_din/waddr/wen: registered scratchpad write port
//   o_spad_chip_en      : tied high
//   o_rd_base           : start row of the oldest resident filter
//   o_filters_avail     : count of complete resident filters
//   o_busy              : FSM not in IDLE
//   o_cfg_err           : 1-cycle pulse when a start is rejected
//   o_stall_cnt         : (FSL_STALL_CNT_EN only) stalled-cycle counter
//   o_dbg_state         : FSM state, for observation
//   o_dbg_free_rows     : free scratchpad rows, for observation
// -----------------------------------------------------------------------------
module filter_spad_loader
    import cnn_acc_pkg::*;
#(
    parameter  int FILTER_WIDTH = FILTER_WIDTH_DEF,
    parameter  int FILTER_ROW   = FILTER_ROW_DEF,
    parameter  int NF_WIDTH     = 8,
    localparam int AW           = clog2(FILTER_ROW)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [AW:0]             i_filter_size,
    input  logic [NF_WIDTH-1:0]     i_num_filters,
    filter_spad_loader_if.slave     s_in,
    input  logic                    i_filter_done,
    output logic [FILTER_WIDTH-1:0] o_spad_din,
    output logic [AW-1:0]           o_spad_waddr,
    output logic                    o_spad_wen,
    output logic                    o_spad_chip_en,
    output logic [AW-1:0]           o_rd_base,
    output logic [AW:0]             o_filters_avail,
    output logic                    o_busy,
    output logic                    o_cfg_err,
`ifdef FSL_STALL_CNT_EN
    output logic [15:0]             o_stall_cnt,
`endif
    output fsl_state_t              o_dbg_state,
    output logic [AW:0]             o_dbg_free_rows
);

    localparam logic [AW:0] ONE_ROW = (AW+1)'(1);
    localparam logic [AW:0] ALL_ROWS = (AW+1)'(FILTER_ROW);

    // FSM and job configuration
    fsl_state_t              r_state;
    logic [AW:0]             r_fsize;
    logic [NF_WIDTH-1:0]     r_nf;
    logic [NF_WIDTH-1:0]     r_filt_cnt;
    logic [AW:0]             r_word_cnt;
    logic                    r_cfg_err;

    // Write path
    logic [AW-1:0]           r_wr_ptr;
    logic                    r_wen;
    logic                    r_wlast;
    logic [FILTER_WIDTH-1:0] r_din;
    logic [AW-1:0]           r_waddr;

    // Bookkeeping
    logic [AW-1:0]           r_rd_base;
    logic [AW:0]             r_free_rows;
    logic [AW:0]             r_filters_avail;

    logic                    w_in_ready;
    logic                    w_hs;
    logic                    w_done_acc;
    logic                    w_word_last;
    logic                    w_filt_last;
    logic                    w_cfg_bad;
    logic                    w_start_acc;
    logic                    w_commit_last;
    logic [AW-1:0]           w_wr_ptr_next;
    logic [AW-1:0]           w_rd_base_next;
    logic [AW:0]             w_free_next;

    // in_ready depends only on state and free space, never on in_valid.
    assign w_in_ready     = (r_state == ST_LOAD) && (r_free_rows != '0);
    assign s_in.in_ready  = w_in_ready;
    assign w_hs           = s_in.in_valid && w_in_ready;

    assign w_word_last    = (r_word_cnt == (r_fsize - ONE_ROW));
    assign w_filt_last    = (r_filt_cnt == (r_nf - NF_WIDTH'(1)));
    assign w_cfg_bad      = (i_filter_size == '0) || (i_filter_size > ALL_ROWS);
    assign w_start_acc    = (r_state == ST_IDLE) && i_start && !w_cfg_bad &&
                            (i_num_filters != '0);

    // A release with nothing resident is dropped entirely.
    assign w_done_acc     = i_filter_done && (r_filters_avail != '0);

    // A filter becomes available only when its last word is committed,
    // i.e. the edge that ends the cycle carrying that registered write.
    assign w_commit_last  = r_wen && r_wlast;

    ring_ptr_add #(
        .AW  (AW),
        .MOD (FILTER_ROW)
    ) u_wr_ptr_add (
        .i_ptr (r_wr_ptr),
        .i_inc (ONE_ROW),
        .o_sum (w_wr_ptr_next)
    );

    ring_ptr_add #(
        .AW  (AW),
        .MOD (FILTER_ROW)
    ) u_rd_base_add (
        .i_ptr (r_rd_base),
        .i_inc (r_fsize),
        .o_sum (w_rd_base_next)
    );

    // Net free-row update; handshake and release in the same cycle combine.
    // A handshake implies at least one free row and a release returns rows
    // that are occupied, so the result stays within 0..FILTER_ROW.
    always_comb begin
        w_free_next = r_free_rows;
        if (w_hs) begin
            w_free_next = w_free_next - ONE_ROW;
        end
        if (w_done_acc) begin
            w_free_next = w_free_next + r_fsize;
        end
    end

    // FSM, job configuration and registered scratchpad write
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_fsize    <= '0;
            r_nf       <= '0;
            r_filt_cnt <= '0;
            r_word_cnt <= '0;
            r_cfg_err  <= 1'b0;
            r_wr_ptr   <= '0;
            r_wen      <= 1'b0;
            r_wlast    <= 1'b0;
            r_din      <= '0;
            r_waddr    <= '0;
        end else begin
            r_cfg_err <= 1'b0;
            r_wen     <= w_hs;
            if (w_hs) begin
                r_din    <= s_in.in_data;
                r_waddr  <= r_wr_ptr;
                r_wlast  <= w_word_last;
                r_wr_ptr <= w_wr_ptr_next;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (w_cfg_bad) begin
                            r_cfg_err <= 1'b1;
                        end else if (w_start_acc) begin
                            r_fsize    <= i_filter_size;
                            r_nf       <= i_num_filters;
                            r_word_cnt <= '0;
                            r_filt_cnt <= '0;
                            r_state    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_hs) begin
                        if (w_word_last) begin
                            r_word_cnt <= '0;
                            r_filt_cnt <= r_filt_cnt + NF_WIDTH'(1);
                            if (w_filt_last) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + ONE_ROW;
                        end
                    end
                end
                // One cycle so the final registered write reaches the scratchpad.
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Resident-filter bookkeeping; persists across IDLE so the consumer can
    // keep draining after the job finishes.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_free_rows     <= ALL_ROWS;
            r_filters_avail <= '0;
            r_rd_base       <= '0;
        end else begin
            r_free_rows <= w_free_next;
            if (w_done_acc) begin
                r_rd_base <= w_rd_base_next;
            end
            unique case ({w_commit_last, w_done_acc})
                2'b10:   r_filters_avail <= r_filters_avail + ONE_ROW;
                2'b01:   r_filters_avail <= r_filters_avail - ONE_ROW;
                default: r_filters_avail <= r_filters_avail;
            endcase
        end
    end

`ifdef FSL_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_LOAD) && s_in.in_valid && !w_in_ready &&
                     (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign o_spad_din      = r_din;
    assign o_spad_waddr    = r_waddr;
    assign o_spad_wen      = r_wen;
    assign o_spad_chip_en  = 1'b1;
    assign o_rd_base       = r_rd_base;
    assign o_filters_avail = r_filters_avail;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_cfg_err       = r_cfg_err;
    assign o_dbg_state     = r_state;
    assign o_dbg_free_rows = r_free_rows;

endmodule
